// File: rtl/safe_lock_pkg.sv
// Shared types and constants for the safe lock controller.
// Holds the FSM state enum, the display message enum and BCD limits.
package safe_lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_SET,
    S_LOCKOUT
  } state_t;

  typedef enum logic [2:0] {
    MSG_LOCKED = 3'd0,
    MSG_ENTRY  = 3'd1,
    MSG_OPEN   = 3'd2,
    MSG_ERROR  = 3'd3,
    MSG_SET    = 3'd4,
    MSG_ALARM  = 3'd5
  } msg_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/safe_lock_timer.sv
// Loadable down-counter shared by the open and lockout phases.
// Ports: clk, rst (sync, high), i_load/i_load_val, i_dec, o_zero.
module safe_lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Saturates at zero so an idle enable never wraps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/safe_lock_ctrl.sv
// Safe locker sequencer: code entry, check, open, code change, lockout.
// Ports: clk, rst, keypad pulses in; unlocked, alarm, msg, digit_cnt, tries_left out.
module safe_lock_ctrl
  import safe_lock_pkg::*;
#(
  parameter int                    CODE_LEN     = 4,
  parameter int                    MAX_TRIES    = 3,
  parameter int                    OPEN_CYC     = 50_000_000,
  parameter int                    LOCKOUT_CYC  = 500_000_000,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic       digit_vld,
  input  logic       enter,
  input  logic       clear,
  input  logic       set_code,
  input  logic       lock_req,
  output logic       unlocked,
  output logic       alarm,
  output logic [2:0] msg,
  output logic [3:0] digit_cnt,
  output logic [2:0] tries_left
);

  localparam int BW   = 4 * CODE_LEN;
  localparam int TMAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] OPEN_LD = TW'(OPEN_CYC - 1);
  localparam logic [TW-1:0] LOCK_LD = TW'(LOCKOUT_CYC - 1);
  localparam logic [3:0]    LEN4    = 4'(CODE_LEN);
  localparam logic [2:0]    TRIES3  = 3'(MAX_TRIES);

  state_t        r_state, w_state_nx;
  logic [BW-1:0] r_buf, w_buf_nx;
  logic [BW-1:0] r_code, w_code_nx;
  logic [3:0]    r_cnt, w_cnt_nx;
  logic [2:0]    r_tries, w_tries_nx;
  logic          r_err, w_err_nx;

  logic          w_tld, w_tdec, w_tzero;
  logic [TW-1:0] w_tval;

  logic          w_dig_ok, w_dig_acc, w_match;
  logic [BW-1:0] w_buf_sh;
  msg_t          w_msg;

  assign w_dig_ok  = digit_vld && (digit_in <= BCD_MAX);
  assign w_dig_acc = w_dig_ok && (r_cnt < LEN4);
  assign w_buf_sh  = {r_buf[BW-5:0], digit_in};
  assign w_match   = (r_cnt == LEN4) && (r_buf == r_code);

  safe_lock_timer #(
    .W(TW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_tld),
    .i_load_val(w_tval),
    .i_dec     (w_tdec),
    .o_zero    (w_tzero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_code  <= DEFAULT_CODE;
      r_cnt   <= '0;
      r_tries <= TRIES3;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_buf   <= w_buf_nx;
      r_code  <= w_code_nx;
      r_cnt   <= w_cnt_nx;
      r_tries <= w_tries_nx;
      r_err   <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_buf_nx   = r_buf;
    w_code_nx  = r_code;
    w_cnt_nx   = r_cnt;
    w_tries_nx = r_tries;
    w_err_nx   = r_err;
    w_tld      = 1'b0;
    w_tval     = OPEN_LD;
    w_tdec     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_dig_ok) begin
          w_buf_nx   = BW'(digit_in);
          w_cnt_nx   = 4'd1;
          w_err_nx   = 1'b0;
          w_state_nx = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (clear) begin
          w_buf_nx   = '0;
          w_cnt_nx   = '0;
          w_state_nx = S_IDLE;
        end else if (enter) begin
          w_state_nx = S_CHECK;
        end else if (w_dig_acc) begin
          w_buf_nx = w_buf_sh;
          w_cnt_nx = r_cnt + 4'd1;
        end
      end

      S_CHECK: begin
        w_buf_nx = '0;
        w_cnt_nx = '0;
        if (w_match) begin
          w_state_nx = S_OPEN;
          w_tries_nx = TRIES3;
          w_err_nx   = 1'b0;
          w_tld      = 1'b1;
        end else if (r_tries <= 3'd1) begin
          // Error flag is dropped so the post-lockout idle shows LOCKED.
          w_state_nx = S_LOCKOUT;
          w_tries_nx = '0;
          w_err_nx   = 1'b0;
          w_tld      = 1'b1;
          w_tval     = LOCK_LD;
        end else begin
          w_state_nx = S_IDLE;
          w_tries_nx = r_tries - 3'd1;
          w_err_nx   = 1'b1;
        end
      end

      S_OPEN: begin
        w_tdec = 1'b1;
        if (lock_req || w_tzero) begin
          w_state_nx = S_IDLE;
        end else if (set_code) begin
          w_state_nx = S_SET;
          w_buf_nx   = '0;
          w_cnt_nx   = '0;
          w_tld      = 1'b1;
        end else if (w_dig_ok) begin
          w_tld = 1'b1;
        end
      end

      S_SET: begin
        w_tdec = 1'b1;
        if (lock_req || w_tzero) begin
          w_state_nx = S_IDLE;
          w_buf_nx   = '0;
          w_cnt_nx   = '0;
        end else if (clear || (enter && (r_cnt != LEN4))) begin
          w_state_nx = S_OPEN;
          w_buf_nx   = '0;
          w_cnt_nx   = '0;
        end else if (enter) begin
          w_code_nx  = r_buf;
          w_state_nx = S_OPEN;
          w_buf_nx   = '0;
          w_cnt_nx   = '0;
          w_tld      = 1'b1;
        end else if (w_dig_acc) begin
          w_buf_nx = w_buf_sh;
          w_cnt_nx = r_cnt + 4'd1;
          w_tld    = 1'b1;
        end
      end

      S_LOCKOUT: begin
        w_tdec = 1'b1;
        if (w_tzero) begin
          w_state_nx = S_IDLE;
          w_tries_nx = TRIES3;
        end
      end

      default: begin
        w_state_nx = S_IDLE;
        w_buf_nx   = '0;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    w_msg = MSG_LOCKED;
    case (r_state)
      S_IDLE:    w_msg = r_err ? MSG_ERROR : MSG_LOCKED;
      S_ENTRY:   w_msg = MSG_ENTRY;
      S_CHECK:   w_msg = MSG_ENTRY;
      S_OPEN:    w_msg = MSG_OPEN;
      S_SET:     w_msg = MSG_SET;
      S_LOCKOUT: w_msg = MSG_ALARM;
      default:   w_msg = MSG_LOCKED;
    endcase
  end

  assign unlocked   = (r_state == S_OPEN) || (r_state == S_SET);
  assign alarm      = (r_state == S_LOCKOUT);
  assign msg        = w_msg;
  assign digit_cnt  = r_cnt;
  assign tries_left = r_tries;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed bench for safe_lock_ctrl: vector table plus corner sequences.
// Short timers (20/50 cycles) keep the timeout and lockout runs small.
module tb_safe_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit_in = 4'd0;
  logic       digit_vld = 1'b0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic       set_code = 1'b0;
  logic       lock_req = 1'b0;
  logic       unlocked, alarm;
  logic [2:0] msg;
  logic [3:0] digit_cnt;
  logic [2:0] tries_left;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  safe_lock_ctrl #(
    .CODE_LEN    (4),
    .MAX_TRIES   (3),
    .OPEN_CYC    (20),
    .LOCKOUT_CYC (50),
    .DEFAULT_CODE(16'h1234)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digit_in  (digit_in),
    .digit_vld (digit_vld),
    .enter     (enter),
    .clear     (clear),
    .set_code  (set_code),
    .lock_req  (lock_req),
    .unlocked  (unlocked),
    .alarm     (alarm),
    .msg       (msg),
    .digit_cnt (digit_cnt),
    .tries_left(tries_left)
  );

  typedef struct {
    logic       dv;
    logic [3:0] d;
    logic [3:0] ctl;
    logic       ul;
    logic       al;
    logic [2:0] msg;
    logic [3:0] cnt;
    logic [2:0] tr;
  } vec_t;

  localparam logic [3:0] N  = 4'b0000;
  localparam logic [3:0] EN = 4'b1000;
  localparam logic [3:0] EC = 4'b1100;
  localparam logic [3:0] CL = 4'b0100;

  vec_t v[27];

  function automatic vec_t mk(
    input logic dv, input logic [3:0] d, input logic [3:0] ctl,
    input logic ul, input logic al, input logic [2:0] m,
    input logic [3:0] c, input logic [2:0] t);
    vec_t r;
    r.dv = dv; r.d = d; r.ctl = ctl; r.ul = ul; r.al = al;
    r.msg = m; r.cnt = c; r.tr = t;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dig(input logic [3:0] d);
    digit_in = d;
    digit_vld = 1'b1;
    step();
    digit_vld = 1'b0;
  endtask

  task automatic ent();
    enter = 1'b1;
    step();
    enter = 1'b0;
  endtask

  // Full code entry; returns once the CHECK cycle has resolved.
  task automatic code4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    dig(a); dig(b); dig(c); dig(d);
    ent();
    step();
  endtask

  initial begin
    v[0]  = mk(1'b1, 4'h1, N,  1'b0, 1'b0, 3'd1, 4'd1, 3'd3);
    v[1]  = mk(1'b1, 4'hA, N,  1'b0, 1'b0, 3'd1, 4'd1, 3'd3);
    v[2]  = mk(1'b1, 4'h2, N,  1'b0, 1'b0, 3'd1, 4'd2, 3'd3);
    v[3]  = mk(1'b0, 4'h0, CL, 1'b0, 1'b0, 3'd0, 4'd0, 3'd3);
    v[4]  = mk(1'b0, 4'h0, EN, 1'b0, 1'b0, 3'd0, 4'd0, 3'd3);
    v[5]  = mk(1'b1, 4'h1, N,  1'b0, 1'b0, 3'd1, 4'd1, 3'd3);
    v[6]  = mk(1'b1, 4'h2, N,  1'b0, 1'b0, 3'd1, 4'd2, 3'd3);
    v[7]  = mk(1'b1, 4'h3, N,  1'b0, 1'b0, 3'd1, 4'd3, 3'd3);
    v[8]  = mk(1'b1, 4'h5, N,  1'b0, 1'b0, 3'd1, 4'd4, 3'd3);
    v[9]  = mk(1'b1, 4'h9, N,  1'b0, 1'b0, 3'd1, 4'd4, 3'd3);
    v[10] = mk(1'b0, 4'h0, EN, 1'b0, 1'b0, 3'd1, 4'd4, 3'd3);
    v[11] = mk(1'b0, 4'h0, N,  1'b0, 1'b0, 3'd3, 4'd0, 3'd2);
    v[12] = mk(1'b1, 4'h1, N,  1'b0, 1'b0, 3'd1, 4'd1, 3'd2);
    v[13] = mk(1'b1, 4'h2, N,  1'b0, 1'b0, 3'd1, 4'd2, 3'd2);
    v[14] = mk(1'b1, 4'h3, N,  1'b0, 1'b0, 3'd1, 4'd3, 3'd2);
    v[15] = mk(1'b0, 4'h0, EC, 1'b0, 1'b0, 3'd0, 4'd0, 3'd2);
    v[16] = mk(1'b1, 4'h1, N,  1'b0, 1'b0, 3'd1, 4'd1, 3'd2);
    v[17] = mk(1'b1, 4'h2, N,  1'b0, 1'b0, 3'd1, 4'd2, 3'd2);
    v[18] = mk(1'b1, 4'h3, N,  1'b0, 1'b0, 3'd1, 4'd3, 3'd2);
    v[19] = mk(1'b0, 4'h0, EN, 1'b0, 1'b0, 3'd1, 4'd3, 3'd2);
    v[20] = mk(1'b0, 4'h0, N,  1'b0, 1'b0, 3'd3, 4'd0, 3'd1);
    v[21] = mk(1'b1, 4'h1, N,  1'b0, 1'b0, 3'd1, 4'd1, 3'd1);
    v[22] = mk(1'b1, 4'h2, N,  1'b0, 1'b0, 3'd1, 4'd2, 3'd1);
    v[23] = mk(1'b1, 4'h3, N,  1'b0, 1'b0, 3'd1, 4'd3, 3'd1);
    v[24] = mk(1'b1, 4'h4, N,  1'b0, 1'b0, 3'd1, 4'd4, 3'd1);
    v[25] = mk(1'b0, 4'h0, EN, 1'b0, 1'b0, 3'd1, 4'd4, 3'd1);
    v[26] = mk(1'b0, 4'h0, N,  1'b1, 1'b0, 3'd2, 4'd0, 3'd3);

    step();
    step();
    rst = 1'b0;
    chk("reset_unlocked", int'(unlocked), 0);
    chk("reset_alarm", int'(alarm), 0);
    chk("reset_msg", int'(msg), 0);
    chk("reset_cnt", int'(digit_cnt), 0);
    chk("reset_tries", int'(tries_left), 3);

    for (int i = 0; i < 27; i++) begin
      digit_vld = v[i].dv;
      digit_in  = v[i].d;
      enter     = v[i].ctl[3];
      clear     = v[i].ctl[2];
      set_code  = v[i].ctl[1];
      lock_req  = v[i].ctl[0];
      step();
      chk($sformatf("vec%0d_unlocked", i), int'(unlocked), int'(v[i].ul));
      chk($sformatf("vec%0d_alarm", i), int'(alarm), int'(v[i].al));
      chk($sformatf("vec%0d_msg", i), int'(msg), int'(v[i].msg));
      chk($sformatf("vec%0d_cnt", i), int'(digit_cnt), int'(v[i].cnt));
      chk($sformatf("vec%0d_tries", i), int'(tries_left), int'(v[i].tr));
    end
    digit_vld = 1'b0; enter = 1'b0; clear = 1'b0;
    set_code = 1'b0; lock_req = 1'b0;

    // Open window: 20 cycles total, the first already sampled above.
    for (int i = 0; i < 19; i++) step();
    chk("open_last_cycle", int'(unlocked), 1);
    step();
    chk("timeout_unlocked", int'(unlocked), 0);
    chk("timeout_msg", int'(msg), 0);

    // Lockout after three wrong codes.
    code4(4'd9, 4'd9, 4'd9, 4'd9);
    chk("wrong1_tries", int'(tries_left), 2);
    code4(4'd9, 4'd9, 4'd9, 4'd9);
    chk("wrong2_tries", int'(tries_left), 1);
    code4(4'd9, 4'd9, 4'd9, 4'd9);
    chk("lockout_alarm", int'(alarm), 1);
    chk("lockout_msg", int'(msg), 5);
    chk("lockout_tries", int'(tries_left), 0);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 49; i++) begin
        digit_in  = 4'(i % 10);
        digit_vld = (i % 3) != 2;
        enter     = (i % 3) == 2;
        step();
        if (!alarm || msg != 3'd5 || digit_cnt != 4'd0 || unlocked) bad++;
      end
      digit_vld = 1'b0;
      enter = 1'b0;
      chk("lockout_ignores_input", bad, 0);
    end
    step();
    chk("lockout_end_alarm", int'(alarm), 0);
    chk("lockout_end_tries", int'(tries_left), 3);
    chk("lockout_end_msg", int'(msg), 0);
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("post_lockout_open", int'(unlocked), 1);

    // Code change: short entry aborts, full entry stores.
    set_code = 1'b1; step(); set_code = 1'b0;
    chk("set_msg", int'(msg), 4);
    chk("set_unlocked", int'(unlocked), 1);
    dig(4'd4);
    ent();
    chk("set_short_msg", int'(msg), 2);
    chk("set_short_cnt", int'(digit_cnt), 0);
    set_code = 1'b1; step(); set_code = 1'b0;
    dig(4'd9); dig(4'd8); dig(4'd7); dig(4'd6);
    ent();
    chk("set_done_msg", int'(msg), 2);
    lock_req = 1'b1; step(); lock_req = 1'b0;
    chk("lock_req_unlocked", int'(unlocked), 0);
    chk("lock_req_msg", int'(msg), 0);
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("old_code_rejected", int'(unlocked), 0);
    chk("old_code_msg", int'(msg), 3);
    code4(4'd9, 4'd8, 4'd7, 4'd6);
    chk("new_code_open", int'(unlocked), 1);
    chk("new_code_tries", int'(tries_left), 3);

    // Extra digits past CODE_LEN are dropped.
    lock_req = 1'b1; step(); lock_req = 1'b0;
    dig(4'd9); dig(4'd8); dig(4'd7); dig(4'd6); dig(4'd1); dig(4'd2);
    chk("six_digits_cnt", int'(digit_cnt), 4);
    ent();
    step();
    chk("six_digits_open", int'(unlocked), 1);

    // Reset in OPEN after a code change restores the default code.
    set_code = 1'b1; step(); set_code = 1'b0;
    dig(4'd5); dig(4'd5); dig(4'd5); dig(4'd5);
    ent();
    chk("code5555_msg", int'(msg), 2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_unlocked", int'(unlocked), 0);
    chk("rst_msg", int'(msg), 0);
    chk("rst_tries", int'(tries_left), 3);
    code4(4'd5, 4'd5, 4'd5, 4'd5);
    chk("rst_code_5555_rejected", int'(unlocked), 0);
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("rst_code_1234_open", int'(unlocked), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
